// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding, requester count and index-to-one-hot helper
package arb_pkg;
   localparam int NREQ = 4;
   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
   function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
      onehot = NREQ'(1) << i;
   endfunction
endpackage

// File: rtl/mux8_4x1.sv
// mux8_4x1: 8-bit 4:1 datapath mux
module mux8_4x1 (
   input  logic [1:0] sel,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   output logic [7:0] y
);
   assign y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/rr_pick4.sv
// rr_pick4: combinational circular priority picker starting at ptr
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] winner,
   output logic       any
);
   logic [3:0] rot;
   logic [1:0] off;
   // rotate so bit 0 is the highest-priority requester, then take the first set bit
   always_comb begin
      rot = 4'({req, req} >> ptr);
      off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
   end
   assign winner = ptr + off;
   assign any    = |req;
endmodule

// File: rtl/rr_arbiter_mux8_4x1.sv
// rr_arbiter_mux8_4x1: round-robin arbiter with hold limit sharing one 8-bit 4:1 mux
module rr_arbiter_mux8_4x1
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic [7:0] out,
   output logic       out_valid,
   output logic       busy
);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
   state_t           state;
   logic [1:0]       ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic [7:0]       mux_y;
   logic [3:0]       pick_req;
   logic [1:0]       pick_ptr;
   logic [1:0]       winner;
   logic             any;
   logic             xfer;
   logic             rel;
   // while granted, search only the other requesters starting just past the grantee
   always_comb begin
      pick_req = (state == ST_GRANT) ? req & ~onehot(sel) : req;
      pick_ptr = (state == ST_GRANT) ? sel + 2'd1 : ptr;
      xfer     = (state == ST_GRANT) && req[sel];
      rel      = (state == ST_GRANT) &&
                 (!req[sel] || (MAX_HOLD != 0 && xfer && any && hold_cnt >= HOLD_LAST));
   end
   rr_pick4 u_pick (
      .req    (pick_req),
      .ptr    (pick_ptr),
      .winner (winner),
      .any    (any)
   );
   mux8_4x1 u_mux (
      .sel (sel),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (mux_y)
   );
   // arbitration state, grant handoff and registered data transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         grant     <= '0;
         sel       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= xfer;
         if (xfer) out <= mux_y;
         if (state == ST_IDLE) begin
            if (any) begin
               grant    <= onehot(winner);
               sel      <= winner;
               hold_cnt <= '0;
               state    <= ST_GRANT;
            end
         end else if (rel) begin
            ptr      <= sel + 2'd1;
            hold_cnt <= '0;
            if (any) begin
               grant <= onehot(winner);
               sel   <= winner;
            end else begin
               grant <= '0;
               state <= ST_IDLE;
            end
         end else if (xfer) begin
            hold_cnt <= (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
         end
      end
   end
   assign busy = (state == ST_GRANT);
endmodule
